// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer.
// Fetches a missing 64-byte line as eight 64-bit beats and writes it into the
// victim way. It then commits the tag. It also runs a full two-way
// invalidate sweep after reset and whenever a flush is requested.
module icache_refill_ctrl #(
   parameter int TAG_W = 50,
   parameter int SET_W = 8,
   parameter int BEATS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     miss_valid,
   input  logic [63:0]              miss_addr,
   input  logic                     miss_victim,
   input  logic                     flush,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [63:0]              mem_req_addr,
   input  logic                     mem_resp_valid,
   input  logic [63:0]              mem_resp_data,
   input  logic                     mem_resp_last,
   output logic                     wr_en,
   output logic [SET_W-1:0]         wr_set,
   output logic                     wr_way,
   output logic [$clog2(BEATS)-1:0] wr_word,
   output logic [63:0]              wr_data,
   output logic                     tag_wr_en,
   output logic [1:0]               tag_wr_mask,
   output logic                     tag_wr_valid,
   output logic [TAG_W-1:0]         tag_wr_tag,
   output logic                     busy,
   output logic                     refill_done,
   output logic                     flush_done,
   output logic                     err
);

   localparam int WORD_W = $clog2(BEATS);
   localparam int OFF_W  = 64 - TAG_W - SET_W;
   localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEATS - 1);
   localparam logic [SET_W-1:0]  LAST_SET  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_COMMIT,
      S_FLUSH
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [TAG_W-1:0]    r_tag;
   logic [SET_W-1:0]    r_set;
   logic                r_victim;
   logic [WORD_W-1:0]   r_beat;
   logic [SET_W-1:0]    r_fcnt;
   logic                r_pend;
   logic                r_err;
   logic                w_start_flush;
   logic                w_take_miss;
   logic                w_beat;
   logic [1:0]          w_vic_mask;
   logic                w_unused_offset;

   // Byte offset within the line never matters: requests are line aligned.
   assign w_unused_offset = ^miss_addr[OFF_W-1:0];

   assign w_start_flush = (r_state == S_IDLE) && (r_pend || flush);
   assign w_take_miss   = (r_state == S_IDLE) && !r_pend && !flush && miss_valid;
   assign w_beat        = (r_state == S_FILL) && mem_resp_valid;
   assign w_vic_mask    = r_victim ? 2'b10 : 2'b01;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state selection; a pending flush always wins over a new miss.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_pend || flush) begin
               w_next = S_FLUSH;
            end else if (miss_valid) begin
               w_next = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               w_next = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_resp_valid && (r_beat == LAST_BEAT)) begin
               w_next = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_next = S_IDLE;
         end
         S_FLUSH: begin
            if (r_fcnt == LAST_SET) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Control counters, deferred-flush flag and sticky beat-protocol error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= 1'b1;
         r_err  <= 1'b0;
         r_beat <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_start_flush) begin
            r_pend <= 1'b0;
            r_fcnt <= '0;
         end else if (r_state == S_FLUSH) begin
            r_fcnt <= r_fcnt + SET_W'(1);
         end
         if (flush && (r_state == S_REQ || r_state == S_FILL || r_state == S_COMMIT)) begin
            r_pend <= 1'b1;
         end
         if (r_state == S_REQ && mem_req_ready) begin
            r_beat <= '0;
         end else if (w_beat) begin
            r_beat <= r_beat + WORD_W'(1);
         end
         // Progress follows the beat count only; a misplaced last marker just flags.
         if (w_beat && (mem_resp_last != (r_beat == LAST_BEAT))) begin
            r_err <= 1'b1;
         end
      end
   end

   // Miss capture: tag, set and victim way of the line being refilled.
   always_ff @(posedge clk) begin
      if (w_take_miss) begin
         r_tag    <= miss_addr[63 -: TAG_W];
         r_set    <= miss_addr[63-TAG_W -: SET_W];
         r_victim <= miss_victim;
      end
   end

   // Output decode; everything is held at zero while reset is asserted.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      wr_en         = 1'b0;
      wr_set        = '0;
      wr_way        = 1'b0;
      wr_word       = '0;
      wr_data       = '0;
      tag_wr_en     = 1'b0;
      tag_wr_mask   = 2'b00;
      tag_wr_valid  = 1'b0;
      tag_wr_tag    = '0;
      busy          = 1'b0;
      refill_done   = 1'b0;
      flush_done    = 1'b0;
      err           = 1'b0;
      if (!reset) begin
         busy         = (r_state != S_IDLE);
         err          = r_err;
         mem_req_addr = {r_tag, r_set, {OFF_W{1'b0}}};
         wr_way       = r_victim;
         tag_wr_tag   = r_tag;
         case (r_state)
            S_REQ: begin
               // Invalidate the victim first so a half-written line never hits.
               mem_req_valid = 1'b1;
               tag_wr_en     = 1'b1;
               tag_wr_mask   = w_vic_mask;
               wr_set        = r_set;
            end
            S_FILL: begin
               wr_en   = mem_resp_valid;
               wr_word = r_beat;
               wr_data = mem_resp_data;
               wr_set  = r_set;
            end
            S_COMMIT: begin
               tag_wr_en    = 1'b1;
               tag_wr_mask  = w_vic_mask;
               tag_wr_valid = 1'b1;
               refill_done  = 1'b1;
               wr_set       = r_set;
            end
            S_FLUSH: begin
               tag_wr_en   = 1'b1;
               tag_wr_mask = 2'b11;
               wr_set      = r_fcnt;
               flush_done  = (r_fcnt == LAST_SET);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: transaction-level reference
// model compared every cycle, plus directed scenarios with literal timing.
module tb_icache_refill_ctrl;

   localparam int TAG_W = 50;
   localparam int SET_W = 8;
   localparam int BEATS = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              miss_valid = 1'b0;
   logic [63:0]       miss_addr = '0;
   logic              miss_victim = 1'b0;
   logic              flush = 1'b0;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic [63:0]       mem_req_addr;
   logic              mem_resp_valid = 1'b0;
   logic [63:0]       mem_resp_data = '0;
   logic              mem_resp_last = 1'b0;
   logic              wr_en;
   logic [SET_W-1:0]  wr_set;
   logic              wr_way;
   logic [2:0]        wr_word;
   logic [63:0]       wr_data;
   logic              tag_wr_en;
   logic [1:0]        tag_wr_mask;
   logic              tag_wr_valid;
   logic [TAG_W-1:0]  tag_wr_tag;
   logic              busy;
   logic              refill_done;
   logic              flush_done;
   logic              err;

   icache_refill_ctrl #(.TAG_W(TAG_W), .SET_W(SET_W), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_victim(miss_victim),
      .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
      .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word), .wr_data(wr_data),
      .tag_wr_en(tag_wr_en), .tag_wr_mask(tag_wr_mask), .tag_wr_valid(tag_wr_valid),
      .tag_wr_tag(tag_wr_tag),
      .busy(busy), .refill_done(refill_done), .flush_done(flush_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // Reference model: what phase the refill/flush activity is in, in
   // transaction terms (words received so far, next set to sweep).
   typedef enum {M_IDLE, M_REQ, M_FILL, M_COMMIT, M_FLUSH} mphase_t;
   mphase_t     m_ph = M_IDLE;
   int          m_words = 0;
   int          m_next_set = 0;
   bit          m_pend = 1'b1;
   bit          m_err = 1'b0;
   logic [63:0] m_line = '0;
   bit          m_vic = 1'b0;

   // Event log observed from the DUT for the directed literal checks.
   int          n_done = 0, n_req = 0, n_fwr = 0, n_wr = 0;
   int          t_done = 0, t_fstart = 0, t_fdone = 0, t_miss = 0;
   logic [63:0] last_req_addr = '0;
   logic [7:0]  last_inv_set = '0;
   logic [1:0]  last_inv_mask = '0;
   logic [63:0] last_commit_tag = '1;

   // Compare on the falling edge, then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_busy", busy, 0);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_tag_wr_en", tag_wr_en, 0);
         chk("rst_mem_req", mem_req_valid, 0);
         chk("rst_refill_done", refill_done, 0);
         chk("rst_flush_done", flush_done, 0);
         chk("rst_err", err, 0);
         m_ph = M_IDLE; m_pend = 1'b1; m_err = 1'b0; m_words = 0; m_next_set = 0;
      end else begin
         chk("busy", busy, m_ph != M_IDLE);
         chk("mem_req_valid", mem_req_valid, m_ph == M_REQ);
         chk("wr_en", wr_en, (m_ph == M_FILL) && mem_resp_valid);
         chk("tag_wr_en", tag_wr_en, m_ph inside {M_REQ, M_COMMIT, M_FLUSH});
         chk("refill_done", refill_done, m_ph == M_COMMIT);
         chk("flush_done", flush_done, (m_ph == M_FLUSH) && (m_next_set == 255));
         chk("err", err, m_err);
         if (m_ph == M_REQ) chk("req_addr", mem_req_addr, m_line);
         if (m_ph == M_FILL && mem_resp_valid) begin
            chk("wr_set", wr_set, m_line[13:6]);
            chk("wr_way", wr_way, m_vic);
            chk("wr_word", wr_word, m_words);
            chk("wr_data", wr_data, mem_resp_data);
         end
         if (m_ph == M_REQ || m_ph == M_COMMIT) begin
            chk("tag_mask", tag_wr_mask, m_vic ? 2'b10 : 2'b01);
            chk("tag_set", wr_set, m_line[13:6]);
            chk("tag_valid", tag_wr_valid, m_ph == M_COMMIT);
         end
         if (m_ph == M_COMMIT) chk("tag_value", tag_wr_tag, m_line >> 14);
         if (m_ph == M_FLUSH) begin
            chk("flush_mask", tag_wr_mask, 2'b11);
            chk("flush_valid", tag_wr_valid, 0);
            chk("flush_set", wr_set, m_next_set);
         end

         if (refill_done) begin n_done++; t_done = cyc; end
         if (mem_req_valid) begin n_req++; last_req_addr = mem_req_addr; end
         if (wr_en) n_wr++;
         if (tag_wr_en && !tag_wr_valid && tag_wr_mask != 2'b11) begin
            last_inv_set = wr_set; last_inv_mask = tag_wr_mask;
         end
         if (tag_wr_en && tag_wr_valid) last_commit_tag = 64'(tag_wr_tag);
         if (tag_wr_en && tag_wr_mask == 2'b11) begin
            n_fwr++;
            if (wr_set == 0) t_fstart = cyc;
         end
         if (flush_done) t_fdone = cyc;

         case (m_ph)
            M_IDLE: begin
               if (m_pend || flush) begin
                  m_pend = 1'b0; m_next_set = 0; m_ph = M_FLUSH;
               end else if (miss_valid) begin
                  m_line = {miss_addr[63:6], 6'b0}; m_vic = miss_victim; m_ph = M_REQ;
               end
            end
            M_REQ: begin
               if (flush) m_pend = 1'b1;
               if (mem_req_ready) begin m_words = 0; m_ph = M_FILL; end
            end
            M_FILL: begin
               if (flush) m_pend = 1'b1;
               if (mem_resp_valid) begin
                  if (mem_resp_last != (m_words == BEATS - 1)) m_err = 1'b1;
                  m_words++;
                  if (m_words == BEATS) m_ph = M_COMMIT;
               end
            end
            M_COMMIT: begin
               if (flush) m_pend = 1'b1;
               m_ph = M_IDLE;
            end
            M_FLUSH: begin
               m_next_set++;
               if (m_next_set == 256) m_ph = M_IDLE;
            end
            default: m_ph = M_IDLE;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      n_done = 0; n_req = 0; n_fwr = 0; n_wr = 0;
      t_done = 0; t_fstart = 0; t_fdone = 0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || m_pend) && k < 2000) begin
         step();
         k++;
      end
      chk("idle_reached", busy | m_pend, 0);
   endtask

   // One refill; gapmask bit b inserts an idle cycle before beat b.
   // bad_beat/flush_beat/rst_beat select a beat index, or -1 for none.
   task automatic refill(input logic [63:0] addr, input bit vic, input int rdly,
                         input logic [7:0] gapmask, input int bad_beat,
                         input int flush_beat, input int rst_beat);
      miss_valid = 1'b1; miss_addr = addr; miss_victim = vic;
      t_miss = cyc;
      step();
      for (int i = 0; i < rdly; i++) begin
         miss_valid = 1'($urandom_range(0, 1)); miss_addr = {$urandom, $urandom};
         mem_req_ready = 1'b0;
         step();
      end
      miss_valid = 1'($urandom_range(0, 1));
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         if (gapmask[b]) begin
            mem_resp_valid = 1'b0; mem_resp_data = {$urandom, $urandom};
            miss_valid = 1'($urandom_range(0, 1));
            step();
         end
         if (b == rst_beat) begin
            mem_resp_valid = 1'b0; mem_resp_last = 1'b0; miss_valid = 1'b0;
            reset = 1'b1;
            step();
            step();
            reset = 1'b0;
            return;
         end
         mem_resp_valid = 1'b1;
         mem_resp_data  = {$urandom, $urandom};
         mem_resp_last  = (b == BEATS - 1) ^ (b == bad_beat);
         flush          = (b == flush_beat);
         miss_valid     = 1'($urandom_range(0, 1));
         step();
         flush = 1'b0;
      end
      mem_resp_valid = 1'b0; mem_resp_last = 1'b0; miss_valid = 1'b0;
      step();
   endtask

   initial begin
      // Reset, then the automatic full invalidate sweep.
      reset = 1'b1;
      step(); step(); step();
      reset = 1'b0;
      clear_log();
      chk("post_reset_idle_busy", busy, 0);
      step();
      chk("flush_starts_busy", busy, 1);
      chk("flush_starts_set0", wr_set, 0);
      wait_idle();
      chk("reset_flush_writes", n_fwr, 256);
      chk("reset_flush_span", t_fdone - t_fstart, 255);

      // Miss at 0x1A4C, victim 1, memory always ready.
      clear_log();
      refill(64'h0000_0000_0000_1A4C, 1'b1, 0, 8'h00, -1, -1, -1);
      wait_idle();
      chk("t1_latency", t_done - t_miss, 10);
      chk("t1_req_addr", last_req_addr, 64'h1A40);
      chk("t1_inv_set", last_inv_set, 8'h69);
      chk("t1_inv_mask", last_inv_mask, 2'b10);
      chk("t1_commit_tag", last_commit_tag, 64'h0);
      chk("t1_writes", n_wr, 8);

      // Ready low three cycles, two gaps between beats.
      clear_log();
      refill(64'h1234_5678_9ABC_DEF0, 1'b0, 3, 8'b0010_0100, -1, -1, -1);
      wait_idle();
      chk("t2_req_cycles", n_req, 4);
      chk("t2_latency", t_done - t_miss, 15);
      chk("t2_writes", n_wr, 8);

      // Flush pulsed during beat 3: refill commits, flush follows one IDLE later.
      clear_log();
      refill(64'hFFFF_0000_0000_3FC0, 1'b1, 1, 8'h00, -1, 3, -1);
      wait_idle();
      chk("t3_done", n_done, 1);
      chk("t3_flush_gap", t_fstart - t_done, 2);
      chk("t3_flush_span", t_fdone - t_fstart, 255);
      chk("t3_flush_writes", n_fwr, 256);

      // Last marker on beat 5: sticky error, still 8 beats then commit.
      clear_log();
      refill(64'h0000_0000_0001_0000, 1'b0, 0, 8'h10, 5, -1, -1);
      wait_idle();
      chk("t4_err", err, 1);
      chk("t4_done", n_done, 1);
      chk("t4_writes", n_wr, 8);
      step(); step(); step();
      chk("t4_err_sticky", err, 1);

      // Reset at beat 4: no commit, error cleared, flush re-runs.
      clear_log();
      refill(64'h0000_0ABC_0000_1240, 1'b1, 0, 8'h00, -1, -1, 4);
      chk("t5_err_cleared", err, 0);
      wait_idle();
      chk("t5_no_done", n_done, 0);
      chk("t5_flush_writes", n_fwr, 256);

      // Randomized refills, occasional flushes and bad last markers.
      for (int it = 0; it < 25; it++) begin
         logic [7:0] gm;
         int bb, fb;
         gm = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
         fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
         refill({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), gm, bb, fb, -1);
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
         end
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
